// File: rtl/rst_seq.sv
// Lock supervisor and reset sequencer for the board clocking tree.
// Optional build macro RST_SEQ_LOSS_RECOVERY_EN: lock loss re-sequences instead of faulting.
module rst_seq #(
    parameter int unsigned NUM_LOCK     = 3,
    parameter int unsigned NUM_RST      = 4,
    parameter int unsigned PLL_RST_CYC  = 8,
    parameter int unsigned LOCK_FILTER  = 16,
    parameter int unsigned STAGE_DLY    = 16,
    parameter int unsigned LOCK_TIMEOUT = 1000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [NUM_LOCK-1:0] locked_i,
    output logic                pll_rst_o,
    output logic [NUM_RST-1:0]  rst_o,
    output logic                all_ready_o,
    output logic                fail_o,
    output logic [3:0]          retry_cnt_o
);

    localparam int unsigned CNT_MAX = (PLL_RST_CYC > LOCK_TIMEOUT)
        ? ((PLL_RST_CYC > STAGE_DLY) ? PLL_RST_CYC : STAGE_DLY)
        : ((LOCK_TIMEOUT > STAGE_DLY) ? LOCK_TIMEOUT : STAGE_DLY);
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
    localparam int unsigned FLT_W = $clog2(LOCK_FILTER + 1);
    localparam int unsigned STG_W = $clog2(NUM_RST + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [FLT_W-1:0]    r_filt, w_filt_nxt;
    logic [STG_W-1:0]    r_stage, w_stage_nxt;
    logic [3:0]          r_retry, w_retry_nxt;
    logic [NUM_RST-1:0]  r_rst, w_rst_nxt;
    logic                r_pll_rst, r_ready, r_fail;
    logic [NUM_LOCK-1:0] r_lock_meta, r_lock_s;
    logic                w_all_lock;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [FLT_W-1:0] flt_inc(input logic [FLT_W-1:0] v);
        return (v == {FLT_W{1'b1}}) ? v : v + FLT_W'(1);
    endfunction

    // Two-flop synchroniser for the asynchronous LOCKED inputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lock_meta <= '0;
            r_lock_s    <= '0;
        end else begin
            r_lock_meta <= locked_i;
            r_lock_s    <= r_lock_meta;
        end
    end

    assign w_all_lock = &r_lock_s;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= S_RESET_PLL;
            r_cnt     <= '0;
            r_filt    <= '0;
            r_stage   <= '0;
            r_retry   <= '0;
            r_rst     <= '1;
            r_pll_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_filt    <= w_filt_nxt;
            r_stage   <= w_stage_nxt;
            r_retry   <= w_retry_nxt;
            r_rst     <= w_rst_nxt;
            r_pll_rst <= (w_state_nxt == S_RESET_PLL);
            r_ready   <= (w_state_nxt == S_RUN);
            r_fail    <= (w_state_nxt == S_FAIL);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_filt_nxt  = r_filt;
        w_stage_nxt = r_stage;
        w_retry_nxt = r_retry;
        w_rst_nxt   = r_rst;

        case (r_state)
            S_RESET_PLL: begin
                if (r_cnt == CNT_W'(PLL_RST_CYC - 1)) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_filt_nxt  = '0;
                end else begin
                    w_cnt_nxt = cnt_inc(r_cnt);
                end
            end
            S_WAIT_LOCK: begin
                // A completed filter wins over a coincident timeout
                if (w_all_lock && (r_filt == FLT_W'(LOCK_FILTER - 1))) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = '0;
                    w_stage_nxt = '0;
                end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_retry < 4'(MAX_RETRY)) begin
                        w_retry_nxt = r_retry + 4'd1;
                        w_state_nxt = S_RESET_PLL;
                    end else begin
                        w_state_nxt = S_FAIL;
                    end
                end else begin
                    w_cnt_nxt  = cnt_inc(r_cnt);
                    w_filt_nxt = w_all_lock ? flt_inc(r_filt) : '0;
                end
            end
            S_RELEASE, S_RUN: begin
                if (!w_all_lock) begin
`ifdef RST_SEQ_LOSS_RECOVERY_EN
                    w_state_nxt = S_RESET_PLL;
                    w_cnt_nxt   = '0;
`else
                    w_state_nxt = S_FAIL;
`endif
                end else if (r_state == S_RELEASE) begin
                    if (r_cnt == CNT_W'(STAGE_DLY - 1)) begin
                        w_cnt_nxt = '0;
                        for (int unsigned k = 0; k < NUM_RST; k++) begin
                            if (STG_W'(k) == r_stage) begin
                                w_rst_nxt[k] = 1'b0;
                            end
                        end
                        if (r_stage == STG_W'(NUM_RST - 1)) begin
                            w_state_nxt = S_RUN;
                            w_retry_nxt = '0;
                        end else begin
                            w_stage_nxt = r_stage + STG_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = cnt_inc(r_cnt);
                    end
                end
            end
            S_FAIL: begin
            end
            default: begin
                w_state_nxt = S_FAIL;
            end
        endcase

        // Domain resets are held in every state except a progressing release or RUN
        case (w_state_nxt)
            S_RESET_PLL, S_WAIT_LOCK, S_FAIL: w_rst_nxt = '1;
            S_RUN:                            w_rst_nxt = '0;
            default: begin
            end
        endcase
    end

    assign pll_rst_o   = r_pll_rst;
    assign rst_o       = r_rst;
    assign all_ready_o = r_ready;
    assign fail_o      = r_fail;
    assign retry_cnt_o = r_retry;

endmodule

// File: doc/rst_seq.md
# rst_seq

Parametrised lock supervisor and reset sequencer for the board clocking tree. It runs on the free-running input reference clock and drives the reset of the DCM/PLL chain. It waits for every lock signal to be stable, then releases a configurable number of active-high domain resets one after another. It also retries clocking primitives that fail to lock and re-sequences, or faults, on lock loss.

## Interface
Parameters:
- NUM_LOCK, 3, number of lock inputs (1..8)
- NUM_RST, 4, number of sequenced reset outputs (1..8)
- PLL_RST_CYC, 8, cycles pll_rst_o is held high per attempt (≥2)
- LOCK_FILTER, 16, consecutive all-locked cycles required (≥1)
- STAGE_DLY, 16, cycles between successive reset releases (≥1)
- LOCK_TIMEOUT, 1000, WAIT_LOCK cycles before an attempt fails
- MAX_RETRY, 3, extra attempts after the first (0..15)

Ports:
- clk_i  in  1  free-running reference clock (IBUFG output); the only clock
- rst_n_i  in  1  asynchronous, active-low reset
- locked_i  in  NUM_LOCK  raw LOCKED outputs, asynchronous to clk_i
- pll_rst_o  out  1  reset to DCM/PLL primitives, active high
- rst_o  out  NUM_RST  domain resets, active high; bit 0 released first
- all_ready_o  out  1  high only in RUN
- fail_o  out  1  sticky lock failure
- retry_cnt_o  out  4  lock timeouts in the current sequence

## Operation
- locked_i passes through a 2-flop synchroniser per bit, giving lock_s. all_lock = &lock_s.
- Counters are $clog2(max+1) bits wide and saturate. None of them wraps.
- States:
  - RESET_PLL: pll_rst_o=1. Exit to WAIT_LOCK after PLL_RST_CYC cycles.
  - WAIT_LOCK: pll_rst_o=0. The filter counter increments while all_lock=1 and clears to 0 when it drops. When the filter reaches LOCK_FILTER, go to RELEASE; this takes priority over timeout in the same cycle. When the timeout counter reaches LOCK_TIMEOUT:
    - if retry_cnt_o < MAX_RETRY: increment retry_cnt_o and go to RESET_PLL;
    - otherwise go to FAIL.
  - RELEASE: rst_o[k] deasserts STAGE_DLY·(k+1) cycles after entry. Once deasserted, a bit stays low. On the deassertion of rst_o[NUM_RST-1], go to RUN.
  - RUN: all_ready_o=1. retry_cnt_o clears to 0 on entry.
  - FAIL: fail_o=1, pll_rst_o=0, all rst_o=1. Only rst_n_i exits this state.
- Lock loss means all_lock=0 in RELEASE or RUN. On the next edge, all rst_o are set to 1 and all_ready_o to 0. The next state is set by the Configuration section.
- Reset values, and the state during rst_n_i low: RESET_PLL with counter 0, pll_rst_o=1, rst_o=all 1s, all_ready_o=0, fail_o=0, retry_cnt_o=0.
- Asserting rst_n_i mid-sequence, including in FAIL, returns all outputs to their reset values immediately.

## Timing
- Edge n is the nth rising clk_i after rst_n_i deasserts.
- All outputs are registered. There is no combinational path from any input to any output.
- A locked_i transition reaches the FSM on the 3rd edge after it occurs.
- Total path latency from a locked_i fall to rst_o assertion is at most 3 edges.
- pll_rst_o falls at edge PLL_RST_CYC.
- With locks already high, RELEASE is entered at edge PLL_RST_CYC+LOCK_FILTER. rst_o[k] falls STAGE_DLY·(k+1) edges later.
- all_ready_o rises on the same edge as the last rst_o falls.
- Each failed attempt costs PLL_RST_CYC+LOCK_TIMEOUT cycles.

## Configuration
- RST_SEQ_LOSS_RECOVERY_EN defined: lock loss in RELEASE or RUN goes to RESET_PLL. retry_cnt_o is unchanged, and the full sequence repeats.
- Not defined: lock loss in RELEASE or RUN goes to FAIL. fail_o=1 and pll_rst_o stays 0.
- The timeout and retry behaviour is identical in both builds.

## Test plan
Use default parameters for all scenarios.
- Locks high from reset:
  - pll_rst_o falls at edge 8.
  - rst_o[0..3] fall at edges 40, 56, 72 and 88.
  - all_ready_o rises at edge 88.
  - fail_o stays 0.
- Locks never assert:
  - pll_rst_o pulses high 4 times, each for 8 cycles.
  - retry_cnt_o steps 1, 2, 3.
  - fail_o rises at edge 4032, with rst_o=0xF and pll_rst_o=0.
- Glitchy lock: locked_i[1] drops for 1 cycle every 10 cycles during WAIT_LOCK, then stays high.
  - RELEASE is entered exactly 16 cycles after the last glitch is visible in lock_s.
  - No timeout occurs if the glitching ends before cycle 900.
- Lock loss in RUN (locked_i[2] low for 5 cycles):
  - rst_o=0xF within 3 edges and all_ready_o=0.
  - With the macro: pll_rst_o pulses again and the full release sequence repeats.
  - Without the macro: fail_o=1.
- First attempt times out, then locks rise at cycle 1500:
  - retry_cnt_o=1 during the second attempt.
  - RUN is reached and retry_cnt_o clears to 0.
- rst_n_i pulsed low during RELEASE, after rst_o[1] has fallen:
  - Outputs return immediately to pll_rst_o=1 and rst_o=0xF.
  - The sequence restarts from edge 0 timing.
